instr_fetch: RTL and testbench

Front end of the 9-bit core. Drives the program counter into the combinational instruction memory read port and captures the returned word into a fetch register. Delivers that word to the decoder over a valid/ready handshake. Handles branch redirects, backpressure and halt detection.

---
 rtl/instr_fetch_if.sv | 36 +++
 rtl/instr_fetch.sv | 110 +++++++++++
 tb/tb_instr_fetch.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_if
// Fetch-stage bus: memory read port, decoder handshake, redirect and status.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface instr_fetch_if #(
  parameter int INSTR_WIDTH = 9,
  parameter int PC_WIDTH    = 8,
  parameter int CNT_WIDTH   = 16
);
  logic                   start;
  logic [PC_WIDTH-1:0]    instr_addr;
  logic [INSTR_WIDTH-1:0] instr_in;
  logic [INSTR_WIDTH-1:0] instr_out;
  logic [PC_WIDTH-1:0]    pc_out;
  logic                   instr_valid;
  logic                   instr_ready;
  logic                   branch_taken;
  logic [PC_WIDTH-1:0]    branch_target;
  logic                   halted;
  logic [CNT_WIDTH-1:0]   fetch_count;

  modport master (
    input  start, instr_in, instr_ready, branch_taken, branch_target,
    output instr_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );

  modport slave (
    output start, instr_in, instr_ready, branch_taken, branch_target,
    input  instr_addr, instr_out, pc_out, instr_valid, halted, fetch_count
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch.sv
//------------------------------------------------------------------------------
// Module : instr_fetch
// 9-bit core front end: PC, fetch register, valid/ready delivery, redirect, halt.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch #(
  parameter int                     ROM_SIZE    = 256,
  parameter int                     INSTR_WIDTH = 9,
  parameter int                     PC_WIDTH    = $clog2(ROM_SIZE),
  parameter logic [INSTR_WIDTH-1:0] HALT_INSTR  = '1,
  parameter int                     CNT_WIDTH   = 16
) (
  input  wire logic      clk,
  input  wire logic      reset,
  instr_fetch_if.master  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [PC_WIDTH-1:0]    r_pc, w_pc_nxt;
  logic [PC_WIDTH-1:0]    r_pc_out, w_pc_out_nxt;
  logic [INSTR_WIDTH-1:0] r_instr, w_instr_nxt;
  logic                   r_valid, w_valid_nxt;
  logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;

  logic w_adv;
  logic w_accept;

  assign w_adv    = !r_valid || bus.instr_ready;
  assign w_accept = r_valid && bus.instr_ready && !bus.branch_taken;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_pc     <= '0;
      r_pc_out <= '0;
      r_instr  <= '0;
      r_valid  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_pc_out <= w_pc_out_nxt;
      r_instr  <= w_instr_nxt;
      r_valid  <= w_valid_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_pc_out_nxt = r_pc_out;
    w_instr_nxt  = r_instr;
    w_valid_nxt  = r_valid;
    w_cnt_nxt    = r_cnt;

    if (w_accept && (r_cnt != {CNT_WIDTH{1'b1}}))
      w_cnt_nxt = r_cnt + CNT_WIDTH'(1);

    unique case (r_state)
      S_IDLE: begin
        if (bus.start)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        // Redirect outranks capture, so a halt word on the wrong path is dropped.
        if (bus.branch_taken) begin
          w_pc_nxt    = bus.branch_target;
          w_valid_nxt = 1'b0;
        end else if (w_adv) begin
          w_instr_nxt  = bus.instr_in;
          w_pc_out_nxt = r_pc;
          w_valid_nxt  = 1'b1;
          if (bus.instr_in == HALT_INSTR)
            w_state_nxt = S_HALT;
          else
            w_pc_nxt = r_pc + PC_WIDTH'(1);
        end
      end
      S_HALT: begin
        if (bus.branch_taken) begin
          w_pc_nxt    = bus.branch_target;
          w_valid_nxt = 1'b0;
          w_state_nxt = S_RUN;
        end else if (r_valid && bus.instr_ready) begin
          w_valid_nxt = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.instr_addr  = r_pc;
  assign bus.instr_out   = r_instr;
  assign bus.pc_out      = r_pc_out;
  assign bus.instr_valid = r_valid;
  assign bus.halted      = (r_state == S_HALT);
  assign bus.fetch_count = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch.sv
//------------------------------------------------------------------------------
// Module : tb_instr_fetch
// Randomized bench for instr_fetch against a transaction-level reference model.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch;

  localparam int         ROM_SIZE = 256;
  localparam int         IW       = 9;
  localparam int         PW       = 8;
  localparam int         CW       = 5;
  localparam logic [8:0] HALT_W   = 9'h1FF;
  localparam int         CNT_MAX  = (1 << CW) - 1;
  localparam int         N_CYC    = 4000;

  logic clk;
  logic reset;
  logic [IW-1:0] rom [ROM_SIZE];

  instr_fetch_if #(.INSTR_WIDTH(IW), .PC_WIDTH(PW), .CNT_WIDTH(CW)) bus ();

  instr_fetch #(
    .ROM_SIZE   (ROM_SIZE),
    .INSTR_WIDTH(IW),
    .PC_WIDTH   (PW),
    .HALT_INSTR (HALT_W),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  assign bus.instr_in = rom[bus.instr_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input int cyc, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Reference model: fetch as a stream of delivered words with a held slot.
  bit         m_started, m_stopped, m_valid;
  int         m_pc, m_pc_out, m_cnt;
  logic [8:0] m_word;

  task automatic model_step(input bit rst, input bit st, input bit rdy, input bit br, input int tgt);
    bit taken;
    if (rst) begin
      m_started = 0; m_stopped = 0; m_valid = 0;
      m_pc = 0; m_pc_out = 0; m_cnt = 0; m_word = '0;
      return;
    end
    taken = m_valid && rdy && !br;
    if (taken && m_cnt < CNT_MAX) m_cnt++;
    if (!m_started) begin
      if (st) m_started = 1;
    end else if (br) begin
      m_pc = tgt; m_valid = 0; m_stopped = 0;
    end else if (m_stopped) begin
      if (taken) m_valid = 0;
    end else if (!m_valid || rdy) begin
      m_word = rom[m_pc]; m_pc_out = m_pc; m_valid = 1;
      if (m_word == HALT_W) m_stopped = 1;
      else m_pc = (m_pc + 1) % ROM_SIZE;
    end
  endtask

  task automatic drive(input bit rst, input bit st, input bit rdy, input bit br, input int tgt);
    reset = rst;
    bus.start = st;
    bus.instr_ready = rdy;
    bus.branch_taken = br;
    bus.branch_target = PW'(tgt);
    model_step(rst, st, rdy, br, tgt);
  endtask

  task automatic check_all(input int cyc);
    chk("instr_addr",  cyc, 32'(bus.instr_addr),  32'(m_pc));
    chk("instr_valid", cyc, 32'(bus.instr_valid), 32'(m_valid));
    chk("instr_out",   cyc, 32'(bus.instr_out),   32'(m_word));
    chk("pc_out",      cyc, 32'(bus.pc_out),      32'(m_pc_out));
    chk("halted",      cyc, 32'(bus.halted),      32'(m_stopped));
    chk("fetch_count", cyc, 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  initial begin
    bit rst, st, rdy, br;
    int tgt, r;

    for (int i = 0; i < ROM_SIZE; i++) begin
      rom[i] = IW'($urandom_range(0, 510));
      if ($urandom_range(0, 39) == 0) rom[i] = HALT_W;
    end
    rom[0] = 9'h0C0; rom[1] = 9'h143; rom[2] = 9'h046; rom[3] = 9'h046;
    rom[4] = 9'h011; rom[5] = 9'h022; rom[6] = 9'h033; rom[7] = HALT_W;
    rom[12] = 9'h0AA; rom[20] = 9'h155; rom[255] = 9'h07E;

    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check_all(-1);
    drive(1, 0, 1, 0, 0);
    @(negedge clk);
    check_all(0);

    for (int c = 1; c <= N_CYC; c++) begin
      // Opening cycles follow the directed sequence; random traffic afterwards.
      if (c == 1)                      begin rst = 0; st = 1; rdy = 1; br = 0; tgt = 0; end
      else if (c < 7)                  begin rst = 0; st = 0; rdy = 1; br = 0; tgt = 0; end
      else if (c >= 7 && c < 10)       begin rst = 0; st = 0; rdy = 0; br = 0; tgt = 0; end
      else if (c < 16)                 begin rst = 0; st = 0; rdy = 1; br = 0; tgt = 0; end
      else if (c == 16)                begin rst = 0; st = 0; rdy = 1; br = 1; tgt = 12; end
      else if (c < 20)                 begin rst = 0; st = 0; rdy = 1; br = 0; tgt = 0; end
      else if (c == 20)                begin rst = 0; st = 0; rdy = 1; br = 1; tgt = 255; end
      else if (c < 25)                 begin rst = 0; st = 0; rdy = 1; br = 0; tgt = 0; end
      else begin
        r   = $urandom_range(0, 3);
        tgt = (r == 0) ? 20 : (r == 1) ? 255 : (r == 2) ? 12 : $urandom_range(0, ROM_SIZE - 1);
        rst = ($urandom_range(0, 299) == 0);
        st  = (!m_started) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
        rdy = (c % 600 < 300) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1);
        br  = ($urandom_range(0, 13) == 0);
      end
      drive(rst, st, rdy, br, tgt);
      @(negedge clk);
      check_all(c);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
